// File: rtl/controle_nivel_temperatura.sv
// controle_nivel_temperatura: sequential temperature alarm-level classifier with N-sample confirmation,
// sharing one half-precision float comparator across the three thresholds.

module comparador_float_sensor (
    input  logic [15:0] valor_a,
    input  logic [15:0] valor_b,
    output logic        eq,
    output logic        lt
);
    logic mag_lt;
    assign mag_lt = valor_a[14:0] < valor_b[14:0];
    // +0 and -0 compare equal
    assign eq = (valor_a == valor_b) || (valor_a[14:0] == 15'd0 && valor_b[14:0] == 15'd0);
    assign lt = !eq && ((valor_a[15] != valor_b[15]) ? valor_a[15] : (valor_a[15] ? !mag_lt : mag_lt));
endmodule

module controle_nivel_temperatura #(
    parameter int unsigned CONFIRMACOES = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        iniciar,
    input  logic [15:0] temp,
    input  logic [15:0] lim_temp1,
    input  logic [15:0] lim_temp2,
    input  logic [15:0] lim_temp3,
    output logic        ocupado,
    output logic        pronto,
    output logic [1:0]  nivel,
    output logic [1:0]  nivel_bruto,
    output logic        alterado
);
    typedef enum logic [1:0] {OCIOSO, COMPARA, DECIDE} estado_t;
    localparam logic [3:0] CONF = 4'(CONFIRMACOES);

    estado_t     state_q;
    logic [15:0] temp_q, lim1_q, lim2_q, lim3_q, valor_b;
    logic [1:0]  indice_q, candidato_q, ultimo_q, nivel_q, nivel_bruto_q;
    logic [3:0]  contador_q, contador_d;
    logic        pronto_q, alterado_q, eq, lt, hit;

    assign valor_b = (indice_q == 2'd0) ? lim1_q : (indice_q == 2'd1) ? lim2_q : lim3_q;

    comparador_float_sensor u_cmp (
        .valor_a (temp_q),
        .valor_b (valor_b),
        .eq      (eq),
        .lt      (lt)
    );

    assign hit = eq | lt;
    assign contador_d = (candidato_q == ultimo_q) ? ((contador_q >= CONF) ? CONF : contador_q + 4'd1) : 4'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= OCIOSO;
            temp_q        <= '0;
            lim1_q        <= '0;
            lim2_q        <= '0;
            lim3_q        <= '0;
            indice_q      <= '0;
            candidato_q   <= '0;
            ultimo_q      <= '0;
            contador_q    <= '0;
            nivel_q       <= '0;
            nivel_bruto_q <= '0;
            pronto_q      <= 1'b0;
            alterado_q    <= 1'b0;
        end else begin
            pronto_q   <= 1'b0;
            alterado_q <= 1'b0;
            case (state_q)
                OCIOSO: if (iniciar) begin
                    temp_q   <= temp;
                    lim1_q   <= lim_temp1;
                    lim2_q   <= lim_temp2;
                    lim3_q   <= lim_temp3;
                    indice_q <= 2'd0;
                    state_q  <= COMPARA;
                end
                COMPARA: if (hit) begin
                    candidato_q <= indice_q;
                    state_q     <= DECIDE;
                end else if (indice_q != 2'd2) begin
                    indice_q <= indice_q + 2'd1;
                end else begin
                    candidato_q <= 2'd3;
                    state_q     <= DECIDE;
                end
                DECIDE: begin
                    nivel_bruto_q <= candidato_q;
                    pronto_q      <= 1'b1;
                    ultimo_q      <= candidato_q;
                    contador_q    <= contador_d;
                    if (contador_d >= CONF && candidato_q != nivel_q) begin
                        nivel_q    <= candidato_q;
                        alterado_q <= 1'b1;
                    end
                    state_q <= OCIOSO;
                end
                default: state_q <= OCIOSO;
            endcase
        end
    end

    assign ocupado     = (state_q != OCIOSO);
    assign pronto      = pronto_q;
    assign nivel       = nivel_q;
    assign nivel_bruto = nivel_bruto_q;
    assign alterado    = alterado_q;
endmodule

// File: tb/tb_controle_nivel_temperatura.sv
// tb_controle_nivel_temperatura: scoreboard bench driving two instances (CONFIRMACOES=1 and 3) in lockstep.

module tb_controle_nivel_temperatura;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        iniciar = 1'b0;
    logic [15:0] temp = 16'h0000;
    logic [15:0] lim1 = 16'h4D00, lim2 = 16'h4F80, lim3 = 16'h5140;
    logic        ocupado1, pronto1, alterado1, ocupado3, pronto3, alterado3;
    logic [1:0]  nivel1, bruto1, nivel3, bruto3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0] lvl;
        logic [1:0] n1;
        logic       a1;
        logic [1:0] n3;
        logic       a3;
        int         issue;
        int         lat;
    } exp_t;
    exp_t q[$];

    logic [1:0] m_ult = 2'd0, m_n1 = 2'd0, m_n3 = 2'd0;
    int m_c1 = 0, m_c3 = 0;

    controle_nivel_temperatura #(.CONFIRMACOES(1)) dut1 (
        .clock(clk), .reset_n(reset_n), .iniciar(iniciar), .temp(temp),
        .lim_temp1(lim1), .lim_temp2(lim2), .lim_temp3(lim3),
        .ocupado(ocupado1), .pronto(pronto1), .nivel(nivel1), .nivel_bruto(bruto1), .alterado(alterado1)
    );

    controle_nivel_temperatura #(.CONFIRMACOES(3)) dut3 (
        .clock(clk), .reset_n(reset_n), .iniciar(iniciar), .temp(temp),
        .lim_temp1(lim1), .lim_temp2(lim2), .lim_temp3(lim3),
        .ocupado(ocupado3), .pronto(pronto3), .nivel(nivel3), .nivel_bruto(bruto3), .alterado(alterado3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(logic [1:0] lvl);
        return (lvl == 2'd0) ? 3 : (lvl == 2'd1) ? 4 : 5;
    endfunction

    task automatic push(logic [1:0] lvl);
        exp_t e;
        m_c1 = (lvl == m_ult) ? ((m_c1 >= 1) ? 1 : m_c1 + 1) : 1;
        m_c3 = (lvl == m_ult) ? ((m_c3 >= 3) ? 3 : m_c3 + 1) : 1;
        e.a1 = (m_c1 >= 1) && (lvl != m_n1);
        if (e.a1) m_n1 = lvl;
        e.a3 = (m_c3 >= 3) && (lvl != m_n3);
        if (e.a3) m_n3 = lvl;
        m_ult   = lvl;
        e.lvl   = lvl;
        e.n1    = m_n1;
        e.n3    = m_n3;
        e.issue = cyc;
        e.lat   = lat_of(lvl);
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic sample(logic [15:0] t, logic [1:0] lvl);
        step();
        temp = t;
        iniciar = 1'b1;
        push(lvl);
        step();
        iniciar = 1'b0;
        drain();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_out1"}, {26'd0, ocupado1, pronto1, nivel1, bruto1, alterado1}, 32'd0);
        chk({tag, "_out3"}, {26'd0, ocupado3, pronto3, nivel3, bruto3, alterado3}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n && (pronto1 || pronto3)) begin
            exp_t e;
            chk("pronto_sync", 32'(pronto3), 32'(pronto1));
            chk("ocupado_at_pronto", 32'(ocupado1), 32'd0);
            if (q.size() == 0) begin
                chk("spurious_pronto", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("nivel_bruto1", 32'(bruto1), 32'(e.lvl));
                chk("nivel_bruto3", 32'(bruto3), 32'(e.lvl));
                chk("nivel1", 32'(nivel1), 32'(e.n1));
                chk("alterado1", 32'(alterado1), 32'(e.a1));
                chk("nivel3", 32'(nivel3), 32'(e.n3));
                chk("alterado3", 32'(alterado3), 32'(e.a3));
                chk("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end else if (reset_n && (alterado1 || alterado3)) begin
            chk("alterado_without_pronto", 32'd1, 32'd0);
        end
    end

    initial begin
        logic [15:0] ht[3] = '{16'h4C00, 16'h5200, 16'h4F80};
        logic [1:0]  hl[3] = '{2'd0, 2'd3, 2'd1};
        // asynchronous reset asserted mid-cycle
        #3 reset_n = 1'b0;
        #1 chk_zero("reset_async");
        step();
        step();
        reset_n = 1'b1;
        repeat (3) begin
            step();
            chk("idle_ocupado", 32'(ocupado1 | ocupado3), 32'd0);
        end

        // per-level latency and boundaries
        sample(16'h4C00, 2'd0);
        sample(16'h4F80, 2'd1);
        sample(16'h5000, 2'd2);
        sample(16'h5200, 2'd3);
        sample(16'h4D00, 2'd0);

        // confirmation
        repeat (4) sample(16'h5200, 2'd3);

        // broken streak after returning to level 0
        repeat (3) sample(16'h4C00, 2'd0);
        sample(16'h5200, 2'd3);
        sample(16'h5200, 2'd3);
        sample(16'h4F80, 2'd1);
        sample(16'h5200, 2'd3);
        sample(16'h5200, 2'd3);

        // iniciar re-pulsed while busy
        step();
        temp = 16'h5200;
        iniciar = 1'b1;
        push(2'd3);
        step();
        iniciar = 1'b0;
        step();
        chk("busy_ocupado", 32'(ocupado1), 32'd1);
        temp = 16'h4C00;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        drain();
        repeat (8) step();

        // inputs changed during COMPARA
        step();
        temp = 16'h5000;
        iniciar = 1'b1;
        push(2'd2);
        step();
        iniciar = 1'b0;
        temp = 16'h4C00;
        lim1 = 16'h5800;
        lim3 = 16'h0000;
        drain();
        lim1 = 16'h4D00;
        lim3 = 16'h5140;

        // iniciar held high
        step();
        iniciar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            temp = ht[i];
            push(hl[i]);
            if (i < 2) repeat (lat_of(hl[i])) step();
        end
        step();
        iniciar = 1'b0;
        drain();
        repeat (6) step();

        // reset mid-classification
        repeat (3) sample(16'h5200, 2'd3);
        step();
        temp = 16'h5200;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        reset_n = 1'b0;
        #1 chk_zero("reset_mid");
        q.delete();
        m_ult = 2'd0;
        m_n1 = 2'd0;
        m_n3 = 2'd0;
        m_c1 = 0;
        m_c3 = 0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        repeat (3) sample(16'h5200, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
